// File: rtl/bcd_to_bin_if.sv
// Handshake and result bus for the 3-digit BCD to binary converter.
// The master side raises start and presents BCD_in; the converter returns the result with a done pulse.
interface bcd_to_bin_if #(
  parameter int DWIDTH = 8
);
  logic              start;
  logic [11:0]       BCD_in;
  logic [DWIDTH-1:0] bin_out;
  logic              busy;
  logic              done;
  logic              ovf;
  logic              err;

  modport master (
    output start,
    output BCD_in,
    input  bin_out,
    input  busy,
    input  done,
    input  ovf,
    input  err
  );

  modport slave (
    input  start,
    input  BCD_in,
    output bin_out,
    output busy,
    output done,
    output ovf,
    output err
  );
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential 3-digit BCD to binary converter (reverse double-dabble, one bit per clock).
// Latency 13 clocks for valid input, 1 clock for a bad digit; start is ignored while busy, no queueing.
module bcd_to_bin #(
  parameter int DWIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  bcd_to_bin_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [11:0] digits;
  logic [11:0] acc;
  logic [3:0]  step;

  logic [23:0] shifted;
  logic [11:0] dig_step;
  logic [11:0] acc_step;
  logic        bad_digit;
  logic        last_step;
  logic        too_big;

  // One reverse double-dabble step: shift the pair right, then correct each digit that reached 8.
  always_comb begin
    shifted  = {digits, acc} >> 1;
    acc_step = shifted[11:0];
    dig_step = shifted[23:12];
    for (int k = 0; k < 3; k++) begin
      if (shifted[12 + 4*k +: 4] >= 4'd8) begin
        dig_step[4*k +: 4] = shifted[12 + 4*k +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    bad_digit = (bus.BCD_in[3:0] > 4'd9) || (bus.BCD_in[7:4] > 4'd9) ||
                (bus.BCD_in[11:8] > 4'd9);
    last_step = (step == 4'd11);
    too_big   = |acc_step[11:DWIDTH];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = bad_digit ? DONE : CONV;
        end
      end
      CONV: begin
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits      <= '0;
      acc         <= '0;
      step        <= '0;
      bus.bin_out <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.ovf     <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      // done trails the DONE state by one clock so it is a pure register output
      bus.done <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            digits <= bus.BCD_in;
            acc    <= '0;
            step   <= '0;
            if (bad_digit) begin
              bus.err     <= 1'b1;
              bus.ovf     <= 1'b0;
              bus.bin_out <= '0;
            end else begin
              bus.busy <= 1'b1;
            end
          end
        end
        CONV: begin
          digits <= dig_step;
          acc    <= acc_step;
          step   <= step + 4'd1;
          if (last_step) begin
            bus.busy <= 1'b0;
            bus.err  <= 1'b0;
            if (too_big) begin
              bus.bin_out <= '1;
              bus.ovf     <= 1'b1;
            end else begin
              bus.bin_out <= acc_step[DWIDTH-1:0];
              bus.ovf     <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed-vector bench for bcd_to_bin: one 8-bit and one 10-bit instance share clock and stimulus.
// Outputs are sampled on the falling edge; all comparisons go through chk.
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] bcd;
  int          n_run = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  bcd_to_bin_if #(.DWIDTH(8))  b8 ();
  bcd_to_bin_if #(.DWIDTH(10)) b10 ();

  assign b8.start   = start;
  assign b8.BCD_in  = bcd;
  assign b10.start  = start;
  assign b10.BCD_in = bcd;

  bcd_to_bin #(.DWIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  bcd_to_bin #(.DWIDTH(10)) dut10 (.clk(clk), .rst_n(rst_n), .bus(b10));

  task automatic chk(input string tag, input int obs, input int exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Accept one conversion, then scramble BCD_in; lat is the cycle index of done (-1 on timeout).
  task automatic go(input logic [11:0] v, output int lat, output int busy_cyc);
    @(negedge clk);
    start = 1'b1;
    bcd   = v;
    @(posedge clk);
    #1;
    start    = 1'b0;
    bcd      = 12'h999;
    lat      = -1;
    busy_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b8.done) begin
        lat = i;
        break;
      end
      if (b8.busy) busy_cyc++;
    end
  endtask

  int lat, bcyc, t1, t2, r1, r2, dcnt, res;

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    bcd   = 12'h000;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_bin", int'(b8.bin_out), 0);
    chk("rst_busy", int'(b8.busy), 0);
    chk("rst_done", int'(b8.done), 0);
    chk("rst_ovf_err", int'({b8.ovf, b8.err}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 255 is the largest value that fits in 8 bits
    go(12'h255, lat, bcyc);
    chk("255_lat", lat, 13);
    chk("255_bin", int'(b8.bin_out), 255);
    chk("255_ovf_err", int'({b8.ovf, b8.err}), 0);
    chk("255_busy_cycles", bcyc, 12);
    @(negedge clk);
    chk("255_done_width", int'(b8.done), 0);

    // back-to-back with start held high
    @(negedge clk);
    start = 1'b1;
    bcd   = 12'h000;
    @(posedge clk);
    #1 bcd = 12'h009;
    t1 = -1; t2 = -1; r1 = -1; r2 = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b8.done) begin
        if (t1 < 0) begin
          t1 = i;
          r1 = int'(b8.bin_out);
        end else begin
          t2 = i;
          r2 = int'(b8.bin_out);
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    chk("b2b_first_lat", t1, 13);
    chk("b2b_first_bin", r1, 0);
    chk("b2b_spacing", t2 - t1, 14);
    chk("b2b_second_bin", r2, 9);

    go(12'h0A5, lat, bcyc);
    chk("bad_lat", lat, 1);
    chk("bad_err", int'(b8.err), 1);
    chk("bad_bin", int'(b8.bin_out), 0);
    chk("bad_ovf", int'(b8.ovf), 0);
    chk("bad_busy", bcyc, 0);

    go(12'h256, lat, bcyc);
    chk("256_bin", int'(b8.bin_out), 255);
    chk("256_ovf", int'(b8.ovf), 1);
    chk("256_err", int'(b8.err), 0);

    go(12'h999, lat, bcyc);
    chk("999_bin8", int'(b8.bin_out), 255);
    chk("999_ovf8", int'(b8.ovf), 1);
    chk("999_bin10", int'(b10.bin_out), 999);
    chk("999_ovf10", int'(b10.ovf), 0);

    // reset in the middle of a conversion
    @(negedge clk);
    start = 1'b1;
    bcd   = 12'h128;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_bin", int'(b8.bin_out), 0);
    chk("abort_busy", int'(b8.busy), 0);
    chk("abort_ovf", int'(b8.ovf), 0);
    chk("abort_done", int'(b8.done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b8.done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    go(12'h128, lat, bcyc);
    chk("128_lat", lat, 13);
    chk("128_bin", int'(b8.bin_out), 128);

    // start pulse during CONV must be ignored
    @(negedge clk);
    start = 1'b1;
    bcd   = 12'h100;
    @(posedge clk);
    #1 start = 1'b0;
    dcnt = 0;
    res  = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 4) begin
        start = 1'b1;
        bcd   = 12'h050;
      end
      if (i == 5) start = 1'b0;
      if (b8.done) begin
        if (dcnt == 0) res = int'(b8.bin_out);
        dcnt++;
      end
    end
    chk("ignore_bin", res, 100);
    chk("ignore_done_cnt", dcnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, binary output width; legal range 4..10.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a conversion; sampled only in IDLE.
REQ-005 SHALL have port BCD_in  input  12  three packed BCD digits, [11:8] hundreds, [7:4] tens, [3:0] units; sampled on the accepting edge.
REQ-006 SHALL have port bin_out  output  DWIDTH  converted binary value; held until the next accepted start.
REQ-007 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse; bin_out, ovf and err are valid when it is high.
REQ-009 SHALL have port ovf  output  1  BCD value exceeds 2^DWIDTH-1.
REQ-010 SHALL have port err  output  1  BCD_in contained a digit greater than 9.

Function
REQ-011 SHALL implement states IDLE, CONV and DONE.
REQ-012 IDLE with start=1: SHALL capture BCD_in, clear the 12-bit internal binary accumulator and the 4-bit step counter, then go to CONV with busy=1.
REQ-013 Capture-time digit check: if any digit is greater than 9, SHALL skip CONV and go directly to DONE.
  - Registered outputs for this case: err=1, ovf=0, bin_out=0.
  - busy stays 0.
REQ-014 CONV: SHALL perform one reverse double-dabble step per clock, 12 steps in total.
  - Each step shifts the {digits, accumulator} pair right by one bit.
  - After the shift, 3 is subtracted from each 4-bit digit whose value is 8 or more.
REQ-015 On the 12th CONV edge, SHALL go to DONE and register the outputs:
  - accumulator at most 2^DWIDTH-1: bin_out = accumulator[DWIDTH-1:0], ovf=0.
  - otherwise: bin_out saturates to all ones, ovf=1.
  - In both cases err=0 and busy falls to 0.
REQ-016 DONE: SHALL hold done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-017 Latency SHALL be fixed:
  - valid input: done is high in the cycle following the 13th rising edge after the accepting edge counted as edge 0, i.e. 13 clocks.
  - invalid input: done follows edge 1.
REQ-018 SHALL ignore start while in CONV or DONE, with no queueing and no effect on the conversion in progress.
REQ-019 SHALL take BCD_in changes after the accepting edge as having no effect on the result.
REQ-020 SHALL keep bin_out, ovf and err stable from DONE until the next accepted start, and leave them unchanged while a new conversion is in CONV.
REQ-021 SHALL return to IDLE with start held permanently high and restart a conversion on the next edge, giving back-to-back conversions every 14 clocks.
REQ-022 SHALL contain no combinational path from any input to any output.

Reset
REQ-023 rst_n=0 SHALL immediately force:
  - state=IDLE, step counter=0 and accumulator=0;
  - bin_out=0, busy=0, done=0, ovf=0 and err=0.
REQ-024 Reset asserted mid-CONV or in DONE SHALL abort the conversion with no done pulse; the first start after release begins a fresh conversion.
REQ-025 Reset deassertion SHALL be safe at any time relative to clk; a start that is high on the first edge after release SHALL be accepted.

Verification
REQ-026 BCD_in=0x255, DWIDTH=8 -> done 13 clocks after accept; bin_out=0xFF, ovf=0, err=0; busy high for exactly 12 cycles.
REQ-027 BCD_in=0x000 and then 0x009 back-to-back with start held high -> bin_out=0x00 then 0x09; done pulses 14 clocks apart.
REQ-028 BCD_in=0x256, and separately 0x999 -> bin_out=0xFF, ovf=1, err=0; with DWIDTH=10, 0x999 -> bin_out=0x3E7, ovf=0.
REQ-029 BCD_in=0x0A5 -> done at edge 1 after accept; err=1, bin_out=0, ovf=0, busy never high.
REQ-030 Accept 0x128, then pulse rst_n low at clock 6 -> all outputs 0 immediately, no done; a later start with 0x128 -> bin_out=0x80.
REQ-031 During CONV of 0x100, pulse start with 0x050 -> ignored; result bin_out=0x64 and exactly one done pulse.
